// File: rtl/inst_decoder_pkg.sv
// inst_decoder_pkg: instruction field positions, phase and error encodings.
// Shared by inst_decoder and inst_checker.
package inst_decoder_pkg;

  localparam int COL_DEF         = 8;
  localparam int TOTAL_CYCLE_DEF = 8;
  localparam int INST_W          = 23;

  localparam int B_PMEM_WR  = 0;
  localparam int B_PMEM_RD  = 1;
  localparam int B_KMEM_WR  = 2;
  localparam int B_KMEM_RD  = 3;
  localparam int B_QMEM_WR  = 4;
  localparam int B_QMEM_RD  = 5;
  localparam int B_LOAD     = 6;
  localparam int B_EXECUTE  = 7;
  localparam int B_PMEM_ADD = 8;
  localparam int B_QMEM_ADD = 12;
  localparam int B_OFIFO_RD = 16;
  localparam int B_SFU_ACC  = 17;
  localparam int B_SFU_DIV  = 18;
  localparam int B_KMEM_ADD = 19;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_KWR  = 3'd1;
  localparam logic [2:0] PH_LOAD = 3'd2;
  localparam logic [2:0] PH_EXEC = 3'd3;
  localparam logic [2:0] PH_SFU  = 3'd4;
  localparam logic [2:0] PH_DONE = 3'd6;
  localparam logic [2:0] PH_ERR  = 3'd7;

  localparam logic [2:0] EC_NONE  = 3'd0;
  localparam logic [2:0] EC_RW    = 3'd1;
  localparam logic [2:0] EC_LDEX  = 3'd2;
  localparam logic [2:0] EC_ORDER = 3'd3;
  localparam logic [2:0] EC_KOVF  = 3'd4;
  localparam logic [2:0] EC_KADD  = 3'd5;

  function automatic logic [3:0] field4(
    input logic [INST_W-1:0] w,
    input int                lsb
  );
    return w[lsb +: 4];
  endfunction

endpackage

// File: rtl/inst_checker.sv
// inst_checker: combinational error detection on the incoming word.
// Only instantiated when INST_DECODER_CHECK_EN is defined.
module inst_checker
  import inst_decoder_pkg::*;
#(
  parameter int col = COL_DEF
) (
  input  logic [2:0]        phase_i,
  input  logic [5:0]        beat_cnt_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              err_o,
  output logic [2:0]        code_o
);

  localparam logic [5:0] ColLim = 6'(col);

  logic       live;
  logic       rw_clash;
  logic       ld_ex;
  logic       skip;
  logic       k_beat;
  logic       k_ovf;
  logic       k_add;
  logic [3:0] kadd;

  assign live = (phase_i <= PH_SFU);

  assign rw_clash =
    (inst_i[B_KMEM_WR] & inst_i[B_KMEM_RD]) |
    (inst_i[B_QMEM_WR] & inst_i[B_QMEM_RD]) |
    (inst_i[B_PMEM_WR] & inst_i[B_PMEM_RD]);

  assign ld_ex = inst_i[B_LOAD] & inst_i[B_EXECUTE];

  assign kadd   = field4(inst_i, B_KMEM_ADD);
  assign k_beat = (phase_i == PH_KWR) & inst_i[B_KMEM_WR];
  assign k_ovf  = k_beat & (beat_cnt_i >= ColLim);
  assign k_add  = k_beat & ({2'b00, kadd} != beat_cnt_i);

  // a trigger is out of order when it jumps past the next phase
  always_comb begin
    skip = 1'b0;
    unique case (phase_i)
      PH_IDLE: skip = inst_i[B_LOAD] | inst_i[B_EXECUTE] |
                      inst_i[B_SFU_ACC];
      PH_KWR:  skip = inst_i[B_EXECUTE] | inst_i[B_SFU_ACC];
      PH_LOAD: skip = inst_i[B_SFU_ACC];
      default: skip = 1'b0;
    endcase
  end

  // lowest code wins when several errors share one word
  always_comb begin
    code_o = EC_NONE;
    if (!live)         code_o = EC_NONE;
    else if (rw_clash) code_o = EC_RW;
    else if (ld_ex)    code_o = EC_LDEX;
    else if (skip)     code_o = EC_ORDER;
    else if (k_ovf)    code_o = EC_KOVF;
    else if (k_add)    code_o = EC_KADD;
  end

  assign err_o = (code_o != EC_NONE);

endmodule

// File: rtl/inst_decoder.sv
// inst_decoder: registered instruction decode plus pass-phase tracker.
// Define INST_DECODER_CHECK_EN to enable error detection (inst_checker).
module inst_decoder
  import inst_decoder_pkg::*;
#(
  parameter int col         = COL_DEF,
  parameter int total_cycle = TOTAL_CYCLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] controller_inst,
  output logic              kmem_wr,
  output logic              kmem_rd,
  output logic              qmem_wr,
  output logic              qmem_rd,
  output logic              pmem_wr,
  output logic              pmem_rd,
  output logic              load,
  output logic              execute,
  output logic              sfu_acc,
  output logic              sfu_div,
  output logic              ofifo_rd,
  output logic [3:0]        kmem_add,
  output logic [3:0]        qmem_add,
  output logic [3:0]        pmem_add,
  output logic [2:0]        phase,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [5:0]        beat_cnt
);

  logic [INST_W-1:0] inst_q;
  logic [2:0]        phase_q, phase_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        cnt_inc;
  logic              div_q, div_d;
  logic              err_q, err_d;
  logic [2:0]        code_q, code_d;

  logic              key_cur;
  logic              key_nxt;
  logic              trig;
  logic [2:0]        phase_nxt;
  logic              chk_err;
  logic [2:0]        chk_code;
  logic              unused_cfg;

  logic w_kwr, w_load, w_exec, w_qrd;
  logic w_pwr, w_sacc, w_sdiv, w_zero;

  assign w_kwr  = controller_inst[B_KMEM_WR];
  assign w_load = controller_inst[B_LOAD];
  assign w_exec = controller_inst[B_EXECUTE];
  assign w_qrd  = controller_inst[B_QMEM_RD];
  assign w_pwr  = controller_inst[B_PMEM_WR];
  assign w_sacc = controller_inst[B_SFU_ACC];
  assign w_sdiv = controller_inst[B_SFU_DIV];
  assign w_zero = (controller_inst == '0);

`ifdef INST_DECODER_CHECK_EN
  inst_checker #(
    .col (col)
  ) u_chk (
    .phase_i    (phase_q),
    .beat_cnt_i (cnt_q),
    .inst_i     (controller_inst),
    .err_o      (chk_err),
    .code_o     (chk_code)
  );
  assign unused_cfg = (total_cycle == 0);
`else
  assign chk_err    = 1'b0;
  assign chk_code   = EC_NONE;
  assign unused_cfg = (col == 0) ^ (total_cycle == 0);
`endif

  assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  // per phase: its counted strobe, its legal trigger and successor
  always_comb begin
    key_cur   = 1'b0;
    key_nxt   = 1'b0;
    trig      = 1'b0;
    phase_nxt = phase_q;
    unique case (phase_q)
      PH_IDLE: begin
        trig      = w_kwr;
        phase_nxt = PH_KWR;
        key_nxt   = w_kwr;
      end
      PH_KWR: begin
        key_cur   = w_kwr;
        trig      = w_load;
        phase_nxt = PH_LOAD;
        key_nxt   = w_load;
      end
      PH_LOAD: begin
        key_cur   = w_load;
        trig      = w_exec;
        phase_nxt = PH_EXEC;
        key_nxt   = w_qrd;
      end
      PH_EXEC: begin
        key_cur   = w_qrd;
        trig      = w_sacc;
        phase_nxt = PH_SFU;
        key_nxt   = w_pwr;
      end
      PH_SFU: begin
        key_cur   = w_pwr;
        trig      = w_zero & div_q;
        phase_nxt = PH_DONE;
        key_nxt   = 1'b0;
      end
      default: begin
        trig      = 1'b0;
      end
    endcase
  end

  // next state; entering ERR keeps the count so the bad beat stays visible
  always_comb begin
    phase_d = phase_q;
    cnt_d   = key_cur ? cnt_inc : cnt_q;
    div_d   = div_q;
    err_d   = err_q;
    code_d  = code_q;
    if ((phase_q == PH_SFU) && w_sdiv) begin
      div_d = 1'b1;
    end
    if (chk_err) begin
      phase_d = PH_ERR;
      err_d   = 1'b1;
      if (!err_q) begin
        code_d = chk_code;
      end
    end else if (trig) begin
      phase_d = phase_nxt;
      cnt_d   = {5'd0, key_nxt};
      if (phase_q == PH_EXEC) begin
        div_d = w_sdiv;
      end
    end
  end

  // capture the word; all decoded outputs are its one-cycle-late copy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q <= '0;
    end else begin
      inst_q <= controller_inst;
    end
  end

  // phase, beat counter and sticky error state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= EC_NONE;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign kmem_wr  = inst_q[B_KMEM_WR];
  assign kmem_rd  = inst_q[B_KMEM_RD];
  assign qmem_wr  = inst_q[B_QMEM_WR];
  assign qmem_rd  = inst_q[B_QMEM_RD];
  assign pmem_wr  = inst_q[B_PMEM_WR];
  assign pmem_rd  = inst_q[B_PMEM_RD];
  assign load     = inst_q[B_LOAD];
  assign execute  = inst_q[B_EXECUTE];
  assign sfu_acc  = inst_q[B_SFU_ACC];
  assign sfu_div  = inst_q[B_SFU_DIV];
  assign ofifo_rd = inst_q[B_OFIFO_RD];
  assign kmem_add = field4(inst_q, B_KMEM_ADD);
  assign qmem_add = field4(inst_q, B_QMEM_ADD);
  assign pmem_add = field4(inst_q, B_PMEM_ADD);

  assign phase    = phase_q;
  assign done     = (phase_q == PH_DONE);
  assign err      = err_q;
  assign err_code = code_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_inst_decoder.sv
// tb_inst_decoder: random and directed passes against a behavioural model.
// Expectations follow INST_DECODER_CHECK_EN when it is defined.
module tb_inst_decoder;

`ifdef INST_DECODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int COL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [22:0] controller_inst = '0;
  logic kmem_wr, kmem_rd, qmem_wr, qmem_rd, pmem_wr, pmem_rd;
  logic load, execute, sfu_acc, sfu_div, ofifo_rd, done, err;
  logic [3:0] kmem_add, qmem_add, pmem_add;
  logic [2:0] phase, err_code;
  logic [5:0] beat_cnt;
  logic [22:0] dec_bus;

  int n_vec = 0;
  int n_bad = 0;

  int          m_phase, m_cnt, m_code;
  bit          m_div, m_err;
  logic [22:0] m_dec;

  inst_decoder #(.col(COL), .total_cycle(8)) dut (
    .clk(clk), .reset(reset), .controller_inst(controller_inst),
    .kmem_wr(kmem_wr), .kmem_rd(kmem_rd),
    .qmem_wr(qmem_wr), .qmem_rd(qmem_rd),
    .pmem_wr(pmem_wr), .pmem_rd(pmem_rd),
    .load(load), .execute(execute),
    .sfu_acc(sfu_acc), .sfu_div(sfu_div), .ofifo_rd(ofifo_rd),
    .kmem_add(kmem_add), .qmem_add(qmem_add), .pmem_add(pmem_add),
    .phase(phase), .done(done), .err(err),
    .err_code(err_code), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  assign dec_bus = {kmem_add, sfu_div, sfu_acc, ofifo_rd, qmem_add,
                    pmem_add, execute, load, qmem_rd, qmem_wr,
                    kmem_rd, kmem_wr, pmem_rd, pmem_wr};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_cnt = 0; m_code = 0;
    m_div = 0; m_err = 0; m_dec = '0;
  endtask

  // phases 1..4 are pass stages; trigger i leads from stage i to i+1
  task automatic m_step(input logic [22:0] w);
    bit trg[4];
    bit key[5];
    int codes[$];
    int s, lo;
    bit live;
    trg = '{w[2], w[6], w[7], w[17]};
    key = '{1'b0, w[2], w[6], w[5], w[0]};
    s = m_phase;
    live = (s <= 4);
    m_dec = w;
    if (CHK && live) begin
      if ((w[2] && w[3]) || (w[4] && w[5]) || (w[0] && w[1]))
        codes.push_back(1);
      if (w[6] && w[7]) codes.push_back(2);
      for (int i = 0; i < 4; i++)
        if (trg[i] && i > s) codes.push_back(3);
      if (s == 1 && w[2] && m_cnt >= COL) codes.push_back(4);
      if (s == 1 && w[2] && int'(w[22:19]) != m_cnt) codes.push_back(5);
    end
    if (s == 4 && w[18]) m_div = 1;
    if (codes.size() > 0) begin
      lo = 99;
      foreach (codes[j]) if (codes[j] < lo) lo = codes[j];
      if (s >= 1 && key[s]) m_cnt = (m_cnt >= 63) ? 63 : m_cnt + 1;
      m_phase = 7;
      if (!m_err) m_code = lo;
      m_err = 1;
    end else if (s <= 3 && trg[s]) begin
      m_phase = s + 1;
      m_cnt = key[s + 1] ? 1 : 0;
      if (s == 3) m_div = w[18];
    end else if (s == 4 && w == '0 && m_div) begin
      m_phase = 6;
      m_cnt = 0;
    end else if (s >= 1 && s <= 4 && key[s]) begin
      m_cnt = (m_cnt >= 63) ? 63 : m_cnt + 1;
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ":dec"}, 32'(dec_bus), 32'(m_dec));
    chk({tag, ":ph"}, 32'(phase), 32'(m_phase));
    chk({tag, ":done"}, 32'(done), (m_phase == 6) ? 32'd1 : 32'd0);
    chk({tag, ":err"}, 32'(err), 32'(m_err));
    chk({tag, ":code"}, 32'(err_code), 32'(m_code));
    chk({tag, ":cnt"}, 32'(beat_cnt), 32'(m_cnt));
  endtask

  task automatic apply(input logic [22:0] w, input string tag);
    @(negedge clk);
    controller_inst = w;
    @(posedge clk);
    #1;
    m_step(w);
    cmp_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    controller_inst = '0;
    #1;
    m_reset();
    cmp_all("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [22:0] noise();
    logic [22:0] w;
    w = '0;
    w[16] = 1'($urandom_range(0, 1));
    w[15:12] = 4'($urandom);
    w[11:8] = 4'($urandom);
    return w;
  endfunction

  function automatic logic [22:0] kbeat(input int k);
    logic [22:0] w;
    w = noise();
    w[2] = 1'b1;
    w[22:19] = 4'(k);
    return w;
  endfunction

  task automatic legal_pass(input int ld_n, input int ex_n,
                            input int pw_n, input int stop_ex);
    logic [22:0] w;
    logic [2:0]  seq[$];
    logic [2:0]  last;
    logic [2:0]  exp_seq[5];
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    last = 3'd0;
    for (int k = 0; k < COL; k++) begin
      if ($urandom_range(0, 3) == 0) apply(noise(), "kfill");
      apply(kbeat(k), "kwr");
      if (phase != last) begin seq.push_back(phase); last = phase; end
    end
    for (int i = 0; i < ld_n; i++) begin
      w = noise(); w[6] = 1'b1;
      apply(w, "load");
      if (phase != last) begin seq.push_back(phase); last = phase; end
    end
    w = noise(); w[7] = 1'b1; w[5] = 1'($urandom);
    apply(w, "exec");
    if (phase != last) begin seq.push_back(phase); last = phase; end
    for (int i = 0; i < ex_n; i++) begin
      w = noise(); w[5] = 1'b1;
      apply(w, "qrd");
      if (stop_ex != 0 && i + 1 == stop_ex) return;
    end
    w = noise(); w[17] = 1'b1; w[0] = 1'($urandom);
    apply(w, "sacc");
    if (phase != last) begin seq.push_back(phase); last = phase; end
    for (int i = 0; i < pw_n; i++) begin
      w = noise(); w[0] = 1'b1;
      apply(w, "pwr");
    end
    w = noise(); w[18] = 1'b1;
    apply(w, "sdiv");
    apply('0, "zero");
    if (phase != last) begin seq.push_back(phase); last = phase; end
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_err", 32'(err), 32'd0);
    for (int i = 0; i < 2; i++) apply(23'($urandom), "dterm");
    chk("pass_hold", 32'(phase), 32'd6);
    chk("trace_len", 32'(seq.size()), 32'd5);
    foreach (seq[i])
      if (i < 5) chk("trace", 32'(seq[i]), 32'(exp_seq[i]));
  endtask

  function automatic logic [22:0] fuzz();
    logic [22:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) w[b] = ($urandom_range(0, 5) == 0);
    w[16] = ($urandom_range(0, 3) == 0);
    w[17] = ($urandom_range(0, 7) == 0);
    w[18] = ($urandom_range(0, 5) == 0);
    w[15:8] = 8'($urandom);
    w[22:19] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 4) == 0) w = '0;
    return w;
  endfunction

  initial begin
    logic [22:0] w;
    int depth, pre;
    m_reset();
    #12;
    cmp_all("por");
    @(negedge clk);
    reset = 1'b1;

    // full legal pass
    legal_pass(1, 8, 8, 0);

    // write+read on kmem inside KWR
    do_reset();
    apply(kbeat(0), "r30a");
    apply(23'h00000C, "r30b");
    chk("r30_err", 32'(err), CHK ? 32'd1 : 32'd0);
    chk("r30_code", 32'(err_code), CHK ? 32'd1 : 32'd0);
    chk("r30_ph", 32'(phase), CHK ? 32'd7 : 32'd1);

    // execute while in KWR
    do_reset();
    apply(kbeat(0), "r31a");
    apply(23'h000080, "r31b");
    chk("r31_code", 32'(err_code), CHK ? 32'd3 : 32'd0);
    chk("r31_ph", 32'(phase), CHK ? 32'd7 : 32'd1);
    chk("r31_err", 32'(err), CHK ? 32'd1 : 32'd0);

    // ninth kmem beat
    do_reset();
    for (int k = 0; k < 9; k++) apply(kbeat(k), "r32");
    chk("r32_code", 32'(err_code), CHK ? 32'd4 : 32'd0);
    chk("r32_cnt", 32'(beat_cnt), 32'd9);

    // qmem clash plus load+execute: lowest code wins
    do_reset();
    apply(kbeat(0), "r34a");
    apply(23'h0000F0, "r34b");
    chk("r34_code", 32'(err_code), CHK ? 32'd1 : 32'd0);
    chk("r34_ph", 32'(phase), CHK ? 32'd7 : 32'd2);
    apply(23'h00000C, "r34c");
    chk("r34_keep", 32'(err_code), CHK ? 32'd1 : 32'd0);

    // asynchronous reset mid EXEC, then a fresh pass
    do_reset();
    legal_pass(1, 8, 8, 4);
    chk("r33_ph", 32'(phase), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    cmp_all("r33_async");
    @(negedge clk);
    controller_inst = '0;
    reset = 1'b1;
    legal_pass(2, 8, 8, 0);

    // long LOAD phase drives beat_cnt into saturation
    do_reset();
    legal_pass(70, 3, 2, 0);

    // random words from random starting depths
    for (int r = 0; r < 12; r++) begin
      do_reset();
      depth = $urandom_range(0, 3);
      pre = $urandom_range(1, 9);
      if (depth >= 1)
        for (int k = 0; k < pre; k++) apply(kbeat(k), "fz_k");
      if (depth >= 2) begin w = '0; w[6] = 1'b1; apply(w, "fz_l"); end
      if (depth >= 3) begin w = '0; w[7] = 1'b1; apply(w, "fz_e"); end
      for (int i = 0; i < 30; i++) apply(fuzz(), "fz");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
